// File: rtl/acc_stream_driver_if.sv
// -----------------------------------------------------------------------------
// acc_stream_driver_if
//   Bundles the stream between the job driver and the floating-point
//   accumulator.
//
//   Bus semantics: there is no backpressure. valid qualifies data for exactly
//   the cycle it is high and the consumer must take it. start and finished are
//   single-cycle strobes that open and close a stream. result is meaningful
//   only while done is high.
//
//   Signals
//     start     driver -> acc   one-cycle accumulator clear
//     valid     driver -> acc   data is a live operand this cycle
//     data      driver -> acc   IEEE-754 single-precision operand
//     finished  driver -> acc   one-cycle end-of-stream marker
//     done      acc -> driver   sum is ready
//     result    acc -> driver   sum, qualified by done
//   Modports: master = driver side, slave = accumulator side.
// -----------------------------------------------------------------------------
interface acc_stream_driver_if;
  logic        start;
  logic        valid;
  logic [31:0] data;
  logic        finished;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, valid, data, finished,
    input  done, result
  );

  modport slave (
    input  start, valid, data, finished,
    output done, result
  );
endinterface

// File: rtl/acc_stream_driver.sv
// -----------------------------------------------------------------------------
// acc_stream_driver
//   On go, reads LENGTH consecutive words from a fixed-latency memory and
//   streams them to the accumulator. It then leaves the adder pipeline idle
//   for FLUSH_CYC cycles, pulses finished, waits for done (or a timeout) and
//   holds the captured sum until the next accepted go.
//
//   Ports
//     clk, reset        clock; synchronous active-high reset
//     go_i              one-cycle job request, honoured only in IDLE
//     base_addr_i       first word address, captured with go
//     length_i          word count, captured with go (0 is legal)
//     busy_o            job in progress (go accepted .. COMPLETE entered)
//     complete_o        one-cycle pulse, result_out_o / error_o valid
//     error_o           accumulator never answered; held until next go
//     result_out_o      captured sum; held until next go
//     mem_addr_o        memory read address
//     mem_read_o        read strobe, one word per cycle
//     mem_readdata_i    read data, MEM_LAT cycles after the strobe
//     acc               accumulator stream (master side)
//     state_o           one-hot FSM state for observation
// -----------------------------------------------------------------------------
module acc_stream_driver #(
  parameter int ADDR_W    = 10,
  parameter int LEN_W     = 16,
  parameter int MEM_LAT   = 2,
  parameter int FLUSH_CYC = 7,
  parameter int TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  input  logic [LEN_W-1:0]      length_i,
  output logic                  busy_o,
  output logic                  complete_o,
  output logic                  error_o,
  output logic [31:0]           result_out_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic                  mem_read_o,
  input  logic [31:0]           mem_readdata_i,
  acc_stream_driver_if.master   acc,
  output logic [7:0]            state_o
);

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [7:0] {
    S_IDLE     = 8'h01,
    S_START    = 8'h02,
    S_ISSUE    = 8'h04,
    S_DRAIN    = 8'h08,
    S_FLUSH    = 8'h10,
    S_FINISH   = 8'h20,
    S_WAIT     = 8'h40,
    S_COMPLETE = 8'h80
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [FW-1:0]       flush_q, flush_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                error_q, error_d;
  logic [31:0]         result_q, result_d;
  logic [MEM_LAT-1:0]  track_q, track_d;
  logic                busy_q, busy_d;
  logic                complete_q, complete_d;
  logic                mem_read_q, mem_read_d;
  logic                start_q, start_d;
  logic                finished_q, finished_d;
  logic                valid_q, valid_d;
  logic [31:0]         data_q, data_d;

  // Next state and datapath updates.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    flush_d  = '0;
    tmo_d    = '0;
    error_d  = error_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (go_i) begin
          state_d  = S_START;
          addr_d   = base_addr_i;
          rem_d    = length_i;
          error_d  = 1'b0;
          result_d = '0;
        end
      end
      S_START: begin
        state_d = (rem_q == '0) ? S_FLUSH : S_ISSUE;
      end
      S_ISSUE: begin
        // rem_q counts down the words still to strobe, so a length of
        // all-ones never needs a wider counter. Address wraps naturally.
        addr_d = addr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        if (rem_q == LEN_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (track_q == '0) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_q == FW'(FLUSH_CYC - 1)) state_d = S_FINISH;
        else                               flush_d = flush_q + 1'b1;
      end
      S_FINISH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (acc.done) begin
          result_d = acc.result;
          state_d  = S_COMPLETE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          error_d  = 1'b1;
          result_d = '0;
          state_d  = S_COMPLETE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_COMPLETE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so each one lines up
  // with the state it belongs to.
  always_comb begin
    busy_d     = !(state_d == S_IDLE || state_d == S_COMPLETE);
    complete_d = (state_d == S_COMPLETE);
    mem_read_d = (state_d == S_ISSUE);
    start_d    = (state_d == S_START);
    finished_d = (state_d == S_FINISH);
    // Bit k set means a strobe issued k+1 cycles ago is still in flight; the
    // top bit marks the cycle its data sits on mem_readdata_i.
    track_d    = MEM_LAT'({track_q, mem_read_q});
    valid_d    = track_q[MEM_LAT-1];
    data_d     = track_q[MEM_LAT-1] ? mem_readdata_i : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      flush_q    <= '0;
      tmo_q      <= '0;
      error_q    <= 1'b0;
      result_q   <= '0;
      track_q    <= '0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
      mem_read_q <= 1'b0;
      start_q    <= 1'b0;
      finished_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      flush_q    <= flush_d;
      tmo_q      <= tmo_d;
      error_q    <= error_d;
      result_q   <= result_d;
      track_q    <= track_d;
      busy_q     <= busy_d;
      complete_q <= complete_d;
      mem_read_q <= mem_read_d;
      start_q    <= start_d;
      finished_q <= finished_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

  assign busy_o       = busy_q;
  assign complete_o   = complete_q;
  assign error_o      = error_q;
  assign result_out_o = result_q;
  assign mem_addr_o   = addr_q;
  assign mem_read_o   = mem_read_q;
  assign acc.start    = start_q;
  assign acc.valid    = valid_q;
  assign acc.data     = data_q;
  assign acc.finished = finished_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_acc_stream_driver.sv
// -----------------------------------------------------------------------------
// tb_acc_stream_driver
//   Three copies of the driver (MEM_LAT 2, 1, 4) share host inputs. Each has
//   its own memory latency pipe and accumulator model. Copy 0 is scoreboarded
//   on every address and data word; copies 1 and 2 are compared on the
//   first job only.
// -----------------------------------------------------------------------------
module tb_acc_stream_driver;

  localparam int F = 7;
  localparam int T = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [15:0] length = '0;

  logic [31:0] mem [1024];
  logic [31:0] model_result = '0;
  logic        model_hang = 1'b0;
  logic        early_done = 1'b0;
  logic        sweep_chk = 1'b0;

  logic        start_w[3], valid_w[3], fin_w[3], memrd_w[3];
  logic        busy_w[3], comp_w[3], err_w[3];
  logic [31:0] data_w[3], res_w[3], rdata_w[3];
  logic [9:0]  addr_w[3];
  logic [7:0]  state_w[3];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int go_cyc = 0;

  int start_cnt[3], rd_cnt[3], val_cnt[3], fin_cnt[3], comp_cnt[3];
  int start_cyc[3], first_rd_cyc[3], first_val_cyc[3], last_val_cyc[3];
  int fin_cyc[3], comp_cyc[3], sidx[3];
  logic prev_rd[3], prev_val[3];
  int b_start[3], b_rd[3], b_val[3], b_fin[3], b_comp[3];
  int excl_viol = 0, zero_viol = 0, unexp_cnt = 0;

  logic [31:0] exp_q[$];
  logic [9:0]  exp_addr_q[$];
  logic [31:0] t1_words[4];

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  // ---------------- DUT copies and models ----------------
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

    acc_stream_driver_if acc_if ();

    acc_stream_driver #(.MEM_LAT(LAT)) u_dut (
      .clk            (clk),
      .reset          (reset),
      .go_i           (go),
      .base_addr_i    (base_addr),
      .length_i       (length),
      .busy_o         (busy_w[g]),
      .complete_o     (comp_w[g]),
      .error_o        (err_w[g]),
      .result_out_o   (res_w[g]),
      .mem_addr_o     (addr_w[g]),
      .mem_read_o     (memrd_w[g]),
      .mem_readdata_i (rdata_w[g]),
      .acc            (acc_if.master),
      .state_o        (state_w[g])
    );

    // Memory: fixed-latency pipe, junk when no read was strobed.
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
      pipe[0] <= memrd_w[g] ? mem[addr_w[g]] : 32'hDEAD_BEEF;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign rdata_w[g] = pipe[LAT-1];

    // Accumulator: done rises two cycles after finished, held until start.
    logic arm_q, mdone_q;
    always @(posedge clk) begin
      if (reset) begin
        arm_q   <= 1'b0;
        mdone_q <= 1'b0;
      end else if (acc_if.start) begin
        arm_q   <= 1'b0;
        mdone_q <= 1'b0;
      end else begin
        arm_q <= acc_if.finished && !model_hang;
        if (arm_q) mdone_q <= 1'b1;
      end
    end
    assign acc_if.done   = mdone_q | early_done;
    assign acc_if.result = early_done ? 32'h1234_5678 : model_result;

    assign start_w[g] = acc_if.start;
    assign valid_w[g] = acc_if.valid;
    assign data_w[g]  = acc_if.data;
    assign fin_w[g]   = acc_if.finished;
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor and scoreboard, sampled on the falling edge.
  initial begin
    for (int i = 0; i < 3; i++) begin
      start_cnt[i] = 0; rd_cnt[i] = 0; val_cnt[i] = 0; fin_cnt[i] = 0; comp_cnt[i] = 0;
      start_cyc[i] = 0; first_rd_cyc[i] = 0; first_val_cyc[i] = 0; last_val_cyc[i] = 0;
      fin_cyc[i] = 0; comp_cyc[i] = 0; sidx[i] = 0; prev_rd[i] = 1'b0; prev_val[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (start_w[i]) begin start_cnt[i]++; start_cyc[i] = cyc; sidx[i] = 0; end
        if (memrd_w[i]) begin
          if (!prev_rd[i]) first_rd_cyc[i] = cyc;
          rd_cnt[i]++;
        end
        if (valid_w[i]) begin
          if (!prev_val[i]) first_val_cyc[i] = cyc;
          last_val_cyc[i] = cyc;
          val_cnt[i]++;
          if (sweep_chk && i > 0) begin
            if (sidx[i] < 4) check_val("sweep_data", data_w[i], t1_words[sidx[i]]);
            sidx[i]++;
          end
        end
        prev_rd[i]  = memrd_w[i];
        prev_val[i] = valid_w[i];
        if (fin_w[i])  begin fin_cnt[i]++;  fin_cyc[i]  = cyc; end
        if (comp_w[i]) begin comp_cnt[i]++; comp_cyc[i] = cyc; end
      end
      if (memrd_w[0]) begin
        if (exp_addr_q.size() == 0) unexp_cnt++;
        else check_val("mem_addr", 32'(addr_w[0]), 32'(exp_addr_q.pop_front()));
      end
      if (valid_w[0]) begin
        if (exp_q.size() == 0) unexp_cnt++;
        else check_val("acc_data", data_w[0], exp_q.pop_front());
      end
      if (int'(start_w[0]) + int'(valid_w[0]) + int'(fin_w[0]) > 1) excl_viol++;
      if (!valid_w[0] && data_w[0] != 32'h0) zero_viol++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic snap();
    for (int i = 0; i < 3; i++) begin
      b_start[i] = start_cnt[i]; b_rd[i] = rd_cnt[i]; b_val[i] = val_cnt[i];
      b_fin[i] = fin_cnt[i]; b_comp[i] = comp_cnt[i];
    end
  endtask

  task automatic start_job(input logic [9:0] b, input logic [15:0] n);
    snap();
    @(posedge clk); #1;
    base_addr = b; length = n; go = 1'b1; go_cyc = cyc;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_job(input int budget);
    int k;
    k = 0;
    while (comp_cnt[0] == b_comp[0] && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (comp_cnt[0] == b_comp[0]) check_val("job_wait_expired", 32'd0, 32'd1);
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_state"}, 32'(state_w[0]), 32'h01);
    check_val({tag, "_ctrl"}, 32'({busy_w[0], comp_w[0], err_w[0], memrd_w[0],
                                  start_w[0], valid_w[0], fin_w[0]}), 32'h0);
    check_val({tag, "_result"}, res_w[0], 32'h0);
    check_val({tag, "_data"}, data_w[0], 32'h0);
    check_val({tag, "_addr"}, 32'(addr_w[0]), 32'h0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
    t1_words[0] = 32'h3F80_0000; t1_words[1] = 32'h4000_0000;
    t1_words[2] = 32'h4040_0000; t1_words[3] = 32'h4080_0000;
    for (int i = 0; i < 4; i++) mem[16 + i] = t1_words[i];

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // 1 / 7: four words, all three latencies.
    model_result = 32'h4120_0000;
    sweep_chk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_addr_q.push_back(10'(16 + i));
      exp_q.push_back(t1_words[i]);
    end
    start_job(10'h010, 16'd4);
    wait_job(200);
    sweep_chk = 1'b0;
    check_val("t1_result", res_w[0], 32'h4120_0000);
    check_val("t1_error", 32'(err_w[0]), 32'd0);
    check_val("t1_busy_after", 32'(busy_w[0]), 32'd0);
    check_val("t1_complete_cnt", 32'(comp_cnt[0] - b_comp[0]), 32'd1);
    check_val("t1_start_cnt", 32'(start_cnt[0] - b_start[0]), 32'd1);
    check_val("t1_valid_cnt", 32'(val_cnt[0] - b_val[0]), 32'd4);
    check_val("t1_read_cnt", 32'(rd_cnt[0] - b_rd[0]), 32'd4);
    check_val("t1_lat2_valid_delay", 32'(first_val_cyc[0] - first_rd_cyc[0]), 32'd3);
    check_val("t1_lat2_go_to_complete", 32'(comp_cyc[0] - go_cyc), 32'd19);
    check_val("t1_flush_gap", 32'(fin_cyc[0] - last_val_cyc[0]), 32'(F + 1));
    check_val("t7_lat1_result", res_w[1], 32'h4120_0000);
    check_val("t7_lat4_result", res_w[2], 32'h4120_0000);
    check_val("t7_lat1_valid_cnt", 32'(val_cnt[1] - b_val[1]), 32'd4);
    check_val("t7_lat4_valid_cnt", 32'(val_cnt[2] - b_val[2]), 32'd4);
    check_val("t7_lat1_valid_delay", 32'(first_val_cyc[1] - first_rd_cyc[1]), 32'd2);
    check_val("t7_lat4_valid_delay", 32'(first_val_cyc[2] - first_rd_cyc[2]), 32'd5);
    check_val("t7_lat1_go_to_complete", 32'(comp_cyc[1] - go_cyc), 32'd18);
    check_val("t7_lat4_go_to_complete", 32'(comp_cyc[2] - go_cyc), 32'd21);

    // 2: zero length, with done forced high before FINISH.
    model_result = 32'h0;
    start_job(10'h100, 16'd0);
    early_done = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    early_done = 1'b0;
    wait_job(200);
    check_val("t2_read_cnt", 32'(rd_cnt[0] - b_rd[0]), 32'd0);
    check_val("t2_valid_cnt", 32'(val_cnt[0] - b_val[0]), 32'd0);
    check_val("t2_start_cnt", 32'(start_cnt[0] - b_start[0]), 32'd1);
    check_val("t2_finish_cnt", 32'(fin_cnt[0] - b_fin[0]), 32'd1);
    check_val("t2_start_to_finish", 32'(fin_cyc[0] - start_cyc[0]), 32'(F + 1));
    check_val("t2_go_to_complete", 32'(comp_cyc[0] - go_cyc), 32'd12);
    check_val("t2_result", res_w[0], 32'h0);

    // 3: address wrap.
    mem[1022] = 32'h1111_0001; mem[1023] = 32'h1111_0002;
    mem[0]    = 32'h1111_0003; mem[1]    = 32'h1111_0004;
    exp_addr_q.push_back(10'h3FE); exp_addr_q.push_back(10'h3FF);
    exp_addr_q.push_back(10'h000); exp_addr_q.push_back(10'h001);
    exp_q.push_back(32'h1111_0001); exp_q.push_back(32'h1111_0002);
    exp_q.push_back(32'h1111_0003); exp_q.push_back(32'h1111_0004);
    model_result = 32'h0BAD_F00D;
    start_job(10'h3FE, 16'd4);
    wait_job(200);
    check_val("t3_result", res_w[0], 32'h0BAD_F00D);
    check_val("t3_valid_cnt", 32'(val_cnt[0] - b_val[0]), 32'd4);
    check_val("t3_addr_left", 32'(exp_addr_q.size()), 32'd0);

    // 4: accumulator never answers, then a clean job clears error.
    model_hang = 1'b1;
    exp_addr_q.push_back(10'h010);
    exp_q.push_back(32'h3F80_0000);
    start_job(10'h010, 16'd1);
    wait_job(400);
    check_val("t4_error", 32'(err_w[0]), 32'd1);
    check_val("t4_result", res_w[0], 32'h0);
    check_val("t4_complete_cnt", 32'(comp_cnt[0] - b_comp[0]), 32'd1);
    check_val("t4_go_to_complete", 32'(comp_cyc[0] - go_cyc), 32'(1 + 2 + F + 3 + T + 1));
    model_hang = 1'b0;
    model_result = 32'h3F80_0000;
    exp_addr_q.push_back(10'h010);
    exp_q.push_back(32'h3F80_0000);
    start_job(10'h010, 16'd1);
    check_val("t4_error_cleared", 32'(err_w[0]), 32'd0);
    wait_job(200);
    check_val("t4_rerun_result", res_w[0], 32'h3F80_0000);
    check_val("t4_rerun_error", 32'(err_w[0]), 32'd0);

    // 5: go held high for the whole job.
    for (int i = 0; i < 8; i++) begin
      mem[64 + i] = 32'h0000_1000 + 32'(i);
      exp_addr_q.push_back(10'(64 + i));
      exp_q.push_back(32'h0000_1000 + 32'(i));
    end
    model_result = 32'h4500_0000;
    snap();
    begin
      int k;
      @(posedge clk); #1;
      base_addr = 10'h040; length = 16'd8; go = 1'b1; go_cyc = cyc;
      k = 0;
      while (!comp_w[0] && k < 200) begin
        @(posedge clk); #1;
        k++;
      end
      if (!comp_w[0]) check_val("t5_wait_expired", 32'd0, 32'd1);
      go = 1'b0;
    end
    repeat (10) @(posedge clk);
    #1;
    check_val("t5_start_cnt", 32'(start_cnt[0] - b_start[0]), 32'd1);
    check_val("t5_complete_cnt", 32'(comp_cnt[0] - b_comp[0]), 32'd1);
    check_val("t5_valid_cnt", 32'(val_cnt[0] - b_val[0]), 32'd8);
    check_val("t5_result", res_w[0], 32'h4500_0000);

    // 6: reset during the third strobe of an eight-word job.
    exp_addr_q.push_back(10'h040); exp_addr_q.push_back(10'h041);
    exp_addr_q.push_back(10'h042);
    start_job(10'h040, 16'd8);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_state("t6_rst");
    repeat (8) @(posedge clk);
    #1;
    check_val("t6_valid_cnt", 32'(val_cnt[0] - b_val[0]), 32'd0);
    check_val("t6_read_cnt", 32'(rd_cnt[0] - b_rd[0]), 32'd3);
    check_val("t6_complete_cnt", 32'(comp_cnt[0] - b_comp[0]), 32'd0);
    mem[32] = 32'h40A0_0000; mem[33] = 32'h40C0_0000;
    exp_addr_q.push_back(10'h020); exp_addr_q.push_back(10'h021);
    exp_q.push_back(32'h40A0_0000); exp_q.push_back(32'h40C0_0000);
    model_result = 32'h4130_0000;
    start_job(10'h020, 16'd2);
    wait_job(200);
    check_val("t6_rerun_result", res_w[0], 32'h4130_0000);
    check_val("t6_rerun_valid_cnt", 32'(val_cnt[0] - b_val[0]), 32'd2);
    check_val("t6_rerun_complete_cnt", 32'(comp_cnt[0] - b_comp[0]), 32'd1);

    // Whole-run invariants.
    check_val("strobe_overlap", 32'(excl_viol), 32'd0);
    check_val("idle_data_nonzero", 32'(zero_viol), 32'd0);
    check_val("unexpected_beats", 32'(unexp_cnt), 32'd0);
    check_val("data_left", 32'(exp_q.size()), 32'd0);
    check_val("addr_left", 32'(exp_addr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
